// File: rtl/ceyloniac_control_unit_pkg.sv
// rtl/ceyloniac_control_unit_pkg.sv - shared encodings for the ceyloniac control path
package ceyloniac_control_unit_pkg;

  localparam int OPCODE_WIDTH = 6;
  localparam int STATE_WIDTH  = 4;

  typedef enum logic [STATE_WIDTH-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_ALU_WB_I  = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10
  } state_e;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] ALU_B_REG    = 2'b00;
  localparam logic [1:0] ALU_B_FOUR   = 2'b01;
  localparam logic [1:0] ALU_B_IMM    = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // Unsupported opcodes fall back to FETCH; the caller flags them as illegal.
  function automatic state_e decode_target(input logic [OPCODE_WIDTH-1:0] op);
    case (op)
      OP_RTYPE:             return S_EXECUTE;
      OP_LW, OP_SW, OP_ADDI: return S_MEM_ADDR;
      OP_BEQ:               return S_BRANCH;
      OP_J:                 return S_JUMP;
      default:              return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/ceyloniac_control_unit_if.sv
// rtl/ceyloniac_control_unit_if.sv - control unit <-> datapath signal bundle
interface ceyloniac_control_unit_if
  import ceyloniac_control_unit_pkg::*;
  ();

  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    mem_ready;
  logic                    zero;
  logic                    pc_write;
  logic                    pc_write_cond;
  logic                    iord;
  logic                    mem_read;
  logic                    mem_write;
  logic                    ir_write;
  logic                    mem_to_reg;
  logic                    reg_dst;
  logic                    reg_write;
  logic                    alu_src_a;
  logic [1:0]              alu_src_b;
  logic [1:0]              alu_op;
  logic [1:0]              pc_source;
  logic                    illegal_op;
  logic [STATE_WIDTH-1:0]  state_out;

  modport master (
    input  opcode, mem_ready, zero,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state_out
  );

  modport slave (
    output opcode, mem_ready, zero,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state_out
  );

endinterface

// File: rtl/ceyloniac_control_decode.sv
// rtl/ceyloniac_control_decode.sv - combinational state to control-signal decode
module ceyloniac_control_decode
  import ceyloniac_control_unit_pkg::*;
(
  input  logic   reset_i,
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    if (reset_i) begin
      case (state_i)
        S_FETCH: begin
          ctrl_o.mem_read  = 1'b1;
          ctrl_o.alu_src_b = ALU_B_FOUR;
          ctrl_o.alu_op    = ALU_OP_ADD;
          ctrl_o.pc_source = PC_SRC_ALU;
          // PC and IR only advance once the RAM has the instruction
          ctrl_o.ir_write  = mem_ready_i;
          ctrl_o.pc_write  = mem_ready_i;
        end
        S_DECODE: begin
          ctrl_o.alu_src_b = ALU_B_IMM_SH;
          ctrl_o.alu_op    = ALU_OP_ADD;
        end
        S_MEM_ADDR: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = ALU_B_IMM;
          ctrl_o.alu_op    = ALU_OP_ADD;
        end
        S_MEM_READ: begin
          ctrl_o.iord     = 1'b1;
          ctrl_o.mem_read = 1'b1;
        end
        S_MEM_WB: begin
          ctrl_o.mem_to_reg = 1'b1;
          ctrl_o.reg_write  = 1'b1;
        end
        S_MEM_WRITE: begin
          ctrl_o.iord      = 1'b1;
          ctrl_o.mem_write = 1'b1;
        end
        S_EXECUTE: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = ALU_B_REG;
          ctrl_o.alu_op    = ALU_OP_FUNCT;
        end
        S_ALU_WB: begin
          ctrl_o.reg_dst   = 1'b1;
          ctrl_o.reg_write = 1'b1;
        end
        S_ALU_WB_I: begin
          ctrl_o.reg_write = 1'b1;
        end
        S_BRANCH: begin
          ctrl_o.alu_src_a     = 1'b1;
          ctrl_o.alu_src_b     = ALU_B_REG;
          ctrl_o.alu_op        = ALU_OP_SUB;
          ctrl_o.pc_source     = PC_SRC_ALUOUT;
          ctrl_o.pc_write_cond = 1'b1;
        end
        S_JUMP: begin
          ctrl_o.pc_source = PC_SRC_JUMP;
          ctrl_o.pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ceyloniac_control_unit.sv
// rtl/ceyloniac_control_unit.sv - multicycle main control FSM with memory-ready stalls
module ceyloniac_control_unit
  import ceyloniac_control_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  ceyloniac_control_unit_if.master  bus
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:     state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        state_d   = decode_target(bus.opcode);
        illegal_d = (state_d == S_FETCH);
      end
      S_MEM_ADDR: begin
        case (bus.opcode)
          OP_LW:   state_d = S_MEM_READ;
          OP_SW:   state_d = S_MEM_WRITE;
          OP_ADDI: state_d = S_ALU_WB_I;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM_READ:  state_d = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_d = S_ALU_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  ceyloniac_control_decode u_decode (
    .reset_i     (reset),
    .state_i     (state_q),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl)
  );

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.iord          = ctrl.iord;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.illegal_op    = illegal_q & reset;
  assign bus.state_out     = reset ? state_q : S_FETCH;

endmodule
